// File: rtl/knn_topk_feeder.sv
// Candidate-side controller for the k-NN min/max priority queue: keeps the K
// smallest-tag candidates resident, then drains them in ascending tag order.
module knn_topk_feeder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 32,
    parameter int unsigned K          = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  cand_valid_in,
    output logic                  cand_ready_out,
    input  logic [DATA_WIDTH-1:0] cand_data_in,
    input  logic [TAG_WIDTH-1:0]  cand_tag_in,
    input  logic                  cand_last_in,
    output logic                  q_enq_out,
    output logic [DATA_WIDTH-1:0] q_enq_data_out,
    output logic [TAG_WIDTH-1:0]  q_enq_tag_out,
    output logic                  q_deq_smallest_out,
    output logic                  q_deq_largest_out,
    input  logic                  q_valid_in,
    input  logic [DATA_WIDTH-1:0] q_data_in,
    input  logic [TAG_WIDTH-1:0]  q_tag_in,
    input  logic [TAG_WIDTH-1:0]  q_max_tag_in,
    input  logic                  q_deq_stall_in,
    output logic                  res_valid_out,
    input  logic                  res_ready_in,
    output logic [DATA_WIDTH-1:0] res_data_out,
    output logic [TAG_WIDTH-1:0]  res_tag_out,
    output logic                  res_last_out,
    output logic                  done_out,
    output logic [$clog2(K):0]    count_out,
    output logic [15:0]           drop_count_out
);

    localparam int unsigned CW = $clog2(K) + 1;

    typedef enum logic [3:0] {
        IDLE, DECIDE, EVICT_WAIT, ENQ, SETTLE,
        DRAIN_REQ, DRAIN_WAIT, DRAIN_OUT, FINISH
    } state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [TAG_WIDTH-1:0]  hold_tag;
    logic                  hold_last;
    logic                  evicted, evicted_next;
    logic                  accepted, accepted_next;
    logic [CW-1:0]         count_next;
    logic [15:0]           drop_next;
    logic                  capture, res_load, deq_largest_next;
    logic                  res_take;

    assign res_take = res_valid_out & res_ready_in;

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state and datapath decisions
    always_comb begin
        state_next       = state;
        count_next       = count_out;
        drop_next        = drop_count_out;
        evicted_next     = evicted;
        accepted_next    = accepted;
        capture          = 1'b0;
        res_load         = 1'b0;
        deq_largest_next = 1'b0;
        case (state)
            IDLE: begin
                if (cand_valid_in && cand_ready_out) begin
                    capture    = 1'b1;
                    state_next = DECIDE;
                end
            end
            DECIDE: begin
                if (count_out < CW'(K)) begin
                    if (!q_deq_stall_in) state_next = ENQ;
                end else if (hold_tag < q_max_tag_in) begin
                    if (!q_deq_stall_in) begin
                        deq_largest_next = 1'b1;
                        evicted_next     = 1'b0;
                        state_next       = EVICT_WAIT;
                    end
                end else begin
                    // ties with the current maximum are rejected
                    if (drop_count_out != 16'hFFFF) drop_next = drop_count_out + 16'd1;
                    state_next = SETTLE;
                end
            end
            EVICT_WAIT: begin
                if (!evicted && q_valid_in) begin
                    evicted_next = 1'b1;
                    count_next   = count_out - CW'(1);
                end
                if ((evicted || q_valid_in) && !q_deq_stall_in) state_next = ENQ;
            end
            ENQ: begin
                count_next = count_out + CW'(1);
                state_next = SETTLE;
            end
            SETTLE: begin
                if (hold_last) state_next = (count_out == '0) ? FINISH : DRAIN_REQ;
                else           state_next = IDLE;
            end
            DRAIN_REQ: state_next = DRAIN_WAIT;
            DRAIN_WAIT: begin
                if (q_valid_in) begin
                    res_load      = 1'b1;
                    count_next    = count_out - CW'(1);
                    accepted_next = 1'b0;
                    state_next    = DRAIN_OUT;
                end
            end
            DRAIN_OUT: begin
                if (res_take) accepted_next = 1'b1;
                if ((accepted || res_take) && !q_deq_stall_in)
                    state_next = (count_out != '0) ? DRAIN_REQ : FINISH;
            end
            FINISH: begin
                drop_next  = 16'd0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs and holding registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hold_data          <= '0;
            hold_tag           <= '0;
            hold_last          <= 1'b0;
            evicted            <= 1'b0;
            accepted           <= 1'b0;
            cand_ready_out     <= 1'b0;
            q_enq_out          <= 1'b0;
            q_enq_data_out     <= '0;
            q_enq_tag_out      <= '0;
            q_deq_smallest_out <= 1'b0;
            q_deq_largest_out  <= 1'b0;
            res_valid_out      <= 1'b0;
            res_data_out       <= '0;
            res_tag_out        <= '0;
            res_last_out       <= 1'b0;
            done_out           <= 1'b0;
            count_out          <= '0;
            drop_count_out     <= '0;
        end else begin
            if (capture) begin
                hold_data <= cand_data_in;
                hold_tag  <= cand_tag_in;
                hold_last <= cand_last_in;
            end
            if (res_load) begin
                res_data_out <= q_data_in;
                res_tag_out  <= q_tag_in;
                res_last_out <= (count_out == CW'(1));
            end
            evicted            <= evicted_next;
            accepted           <= accepted_next;
            cand_ready_out     <= (state_next == IDLE);
            q_enq_out          <= (state_next == ENQ);
            q_enq_data_out     <= hold_data;
            q_enq_tag_out      <= hold_tag;
            q_deq_smallest_out <= (state_next == DRAIN_REQ);
            q_deq_largest_out  <= deq_largest_next;
            res_valid_out      <= (state_next == DRAIN_OUT) && !accepted_next;
            done_out           <= (state_next == FINISH);
            count_out          <= count_next;
            drop_count_out     <= drop_next;
        end
    end

endmodule

// File: tb/tb_knn_topk_feeder.sv
// Bench for knn_topk_feeder: behavioural min/max queue, top-K reference model
// built from sorted lists, and protocol monitors.
module tb_knn_topk_feeder;

    localparam int unsigned DW    = 32;
    localparam int unsigned TW    = 32;
    localparam int unsigned K     = 8;
    localparam int unsigned CW    = $clog2(K) + 1;
    localparam int          LAT   = 2;
    localparam int          STALL = K;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          cand_valid_in, cand_ready_out, cand_last_in;
    logic [DW-1:0] cand_data_in;
    logic [TW-1:0] cand_tag_in;
    logic          q_enq_out, q_deq_smallest_out, q_deq_largest_out;
    logic [DW-1:0] q_enq_data_out, q_data_in, res_data_out;
    logic [TW-1:0] q_enq_tag_out, q_tag_in, q_max_tag_in, res_tag_out;
    logic          q_valid_in, q_deq_stall_in;
    logic          res_valid_out, res_ready_in, res_last_out, done_out;
    logic [CW-1:0] count_out;
    logic [15:0]   drop_count_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    knn_topk_feeder #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .K(K)) dut (
        .clk_in(clk), .rst_in(rst_in),
        .cand_valid_in(cand_valid_in), .cand_ready_out(cand_ready_out),
        .cand_data_in(cand_data_in), .cand_tag_in(cand_tag_in), .cand_last_in(cand_last_in),
        .q_enq_out(q_enq_out), .q_enq_data_out(q_enq_data_out), .q_enq_tag_out(q_enq_tag_out),
        .q_deq_smallest_out(q_deq_smallest_out), .q_deq_largest_out(q_deq_largest_out),
        .q_valid_in(q_valid_in), .q_data_in(q_data_in), .q_tag_in(q_tag_in),
        .q_max_tag_in(q_max_tag_in), .q_deq_stall_in(q_deq_stall_in),
        .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
        .res_data_out(res_data_out), .res_tag_out(res_tag_out), .res_last_out(res_last_out),
        .done_out(done_out), .count_out(count_out), .drop_count_out(drop_count_out)
    );

    function automatic logic [DW-1:0] dfun(input logic [TW-1:0] t);
        return DW'(t * 32'h9E37_79B1 + 32'h0000_1234);
    endfunction

    // Behavioural priority queue: fixed dequeue latency, then a rescan stall
    logic [TW-1:0] mq_tag[$];
    logic [DW-1:0] mq_data[$];
    int            pend_cnt, stall_cnt, viol_proto;
    logic [TW-1:0] pend_tag;
    logic [DW-1:0] pend_data;

    always @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            mq_tag.delete();
            mq_data.delete();
            pend_cnt = 0;
            stall_cnt = 0;
            q_valid_in     <= 1'b0;
            q_data_in      <= '0;
            q_tag_in       <= '0;
            q_deq_stall_in <= 1'b0;
            q_max_tag_in   <= '0;
        end else begin
            int idx;
            logic [TW-1:0] mx;
            if ((q_enq_out || q_deq_smallest_out || q_deq_largest_out) && (pend_cnt > 0 || q_deq_stall_in))
                viol_proto++;
            if (int'(q_enq_out) + int'(q_deq_smallest_out) + int'(q_deq_largest_out) > 1)
                viol_proto++;
            q_valid_in <= 1'b0;
            if (stall_cnt > 0) stall_cnt--;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    q_valid_in <= 1'b1;
                    q_tag_in   <= pend_tag;
                    q_data_in  <= pend_data;
                    stall_cnt = STALL;
                end
            end
            if (q_enq_out) begin
                if (mq_tag.size() >= int'(K)) viol_proto++;
                mq_tag.push_back(q_enq_tag_out);
                mq_data.push_back(q_enq_data_out);
            end
            if (q_deq_smallest_out || q_deq_largest_out) begin
                if (mq_tag.size() == 0) viol_proto++;
                else begin
                    idx = 0;
                    foreach (mq_tag[i])
                        if (q_deq_largest_out ? (mq_tag[i] > mq_tag[idx]) : (mq_tag[i] < mq_tag[idx])) idx = i;
                    pend_tag  = mq_tag[idx];
                    pend_data = mq_data[idx];
                    mq_tag.delete(idx);
                    mq_data.delete(idx);
                    pend_cnt = LAT;
                end
            end
            mx = '0;
            foreach (mq_tag[i]) if (mq_tag[i] > mx) mx = mq_tag[i];
            q_deq_stall_in <= (stall_cnt > 0);
            q_max_tag_in   <= mx;
        end
    end

    // Downstream backpressure: 0 always ready, 1 random, 2 ten-cycle hold per entry
    int bp_mode = 0;
    int bp_wait = 0;
    always begin
        @(posedge clk);
        #1;
        if (bp_mode == 0) res_ready_in = 1'b1;
        else if (bp_mode == 1) res_ready_in = 1'($urandom_range(0, 1));
        else if (!res_valid_out) begin bp_wait = 0; res_ready_in = 1'b0; end
        else if (bp_wait < 10) begin bp_wait++; res_ready_in = 1'b0; end
        else res_ready_in = 1'b1;
    end

    // Monitor: collects strobes and results, flags unstable or overlong outputs
    int            n_enq, n_evict, n_dsm, n_done, viol_mon;
    logic [15:0]   drop_at_done;
    logic [TW-1:0] res_tags[$];
    logic [DW-1:0] res_datas[$];
    logic          res_lasts[$];
    logic          prev_hold, prev_last, prev_enq, prev_dl, prev_ds, prev_done;
    logic [TW-1:0] prev_tag;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        if (!rst_in) begin
            prev_hold = 0; prev_enq = 0; prev_dl = 0; prev_ds = 0; prev_done = 0;
        end else begin
            if (q_enq_out) n_enq++;
            if (q_deq_largest_out) n_evict++;
            if (q_deq_smallest_out) n_dsm++;
            if (done_out) begin n_done++; drop_at_done = drop_count_out; end
            if ((q_enq_out && prev_enq) || (q_deq_largest_out && prev_dl) ||
                (q_deq_smallest_out && prev_ds) || (done_out && prev_done)) viol_mon++;
            if (prev_hold && (!res_valid_out || res_tag_out !== prev_tag ||
                res_data_out !== prev_data || res_last_out !== prev_last)) viol_mon++;
            if (res_valid_out && !res_ready_in && q_deq_smallest_out) viol_mon++;
            if (res_valid_out && res_ready_in) begin
                res_tags.push_back(res_tag_out);
                res_datas.push_back(res_data_out);
                res_lasts.push_back(res_last_out);
            end
            prev_hold = res_valid_out && !res_ready_in;
            prev_tag  = res_tag_out;
            prev_data = res_data_out;
            prev_last = res_last_out;
            prev_enq  = q_enq_out;
            prev_dl   = q_deq_largest_out;
            prev_ds   = q_deq_smallest_out;
            prev_done = done_out;
        end
    end

    // Top-K reference: resident set as a list, evict the maximum on a strictly better tag
    logic [TW-1:0] exp_tags[$];
    int exp_drops, exp_evicts, exp_enqs;

    function automatic void ref_model(input logic [TW-1:0] cands[$]);
        exp_tags.delete();
        exp_drops = 0; exp_evicts = 0; exp_enqs = 0;
        foreach (cands[c]) begin
            if (exp_tags.size() < int'(K)) begin
                exp_tags.push_back(cands[c]);
                exp_enqs++;
            end else begin
                int m = 0;
                foreach (exp_tags[i]) if (exp_tags[i] > exp_tags[m]) m = i;
                if (cands[c] < exp_tags[m]) begin
                    exp_tags.delete(m);
                    exp_tags.push_back(cands[c]);
                    exp_evicts++;
                    exp_enqs++;
                end else exp_drops++;
            end
        end
        exp_tags.sort();
    endfunction

    task automatic clear_stats();
        n_enq = 0; n_evict = 0; n_dsm = 0; n_done = 0; viol_mon = 0; viol_proto = 0;
        drop_at_done = '0;
        res_tags.delete(); res_datas.delete(); res_lasts.delete();
    endtask

    task automatic send_cand(input logic [TW-1:0] tag, input logic last);
        int t = 0;
        @(negedge clk);
        while (!cand_ready_out && t < 2000) begin @(negedge clk); t++; end
        checks++;
        if (t >= 2000) begin
            failures++;
            $display("FAIL cand_ready_timeout: waited %0d cycles, required < 2000", t);
        end
        cand_valid_in = 1'b1;
        cand_tag_in   = tag;
        cand_data_in  = dfun(tag);
        cand_last_in  = last;
        @(negedge clk);
        cand_valid_in = 1'b0;
        cand_last_in  = 1'b0;
    endtask

    task automatic run_query(input string name, input logic [TW-1:0] cands[$], input int mode);
        int t = 0;
        int n;
        clear_stats();
        bp_mode = mode;
        ref_model(cands);
        foreach (cands[i]) send_cand(cands[i], 1'(i == cands.size() - 1));
        while (n_done == 0 && t < 5000) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        checks++;
        if (n_done !== 1) begin failures++; $display("FAIL %s done_pulses: got %0d need 1", name, n_done); end
        checks++;
        if (res_tags.size() !== exp_tags.size()) begin
            failures++;
            $display("FAIL %s result_count: got %0d need %0d", name, res_tags.size(), exp_tags.size());
        end
        n = (res_tags.size() < exp_tags.size()) ? res_tags.size() : exp_tags.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (res_tags[i] !== exp_tags[i] || res_datas[i] !== dfun(exp_tags[i]) ||
                res_lasts[i] !== 1'(i == exp_tags.size() - 1)) begin
                failures++;
                $display("FAIL %s result[%0d]: got tag %0d data %h last %0b need tag %0d data %h last %0b",
                         name, i, res_tags[i], res_datas[i], res_lasts[i], exp_tags[i],
                         dfun(exp_tags[i]), i == exp_tags.size() - 1);
            end
        end
        checks++;
        if (n_enq !== exp_enqs || n_evict !== exp_evicts || n_dsm !== exp_tags.size()) begin
            failures++;
            $display("FAIL %s strobes: got enq %0d evict %0d deqmin %0d need %0d %0d %0d",
                     name, n_enq, n_evict, n_dsm, exp_enqs, exp_evicts, exp_tags.size());
        end
        checks++;
        if (drop_at_done !== 16'(exp_drops)) begin
            failures++;
            $display("FAIL %s drop_count: got %0d need %0d", name, drop_at_done, exp_drops);
        end
        checks++;
        if (count_out !== '0 || drop_count_out !== '0 || cand_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL %s post_state: got count %0d drops %0d ready %0b need 0 0 1",
                     name, count_out, drop_count_out, cand_ready_out);
        end
        checks++;
        if (viol_mon !== 0 || viol_proto !== 0) begin
            failures++;
            $display("FAIL %s protocol: got %0d/%0d violations need 0", name, viol_mon, viol_proto);
        end
    endtask

    task automatic test_reset();
        logic any_out;
        rst_in = 1'b0;
        cand_valid_in = 0; cand_last_in = 0; cand_data_in = '0; cand_tag_in = '0;
        repeat (3) @(negedge clk);
        any_out = |{cand_ready_out, q_enq_out, q_deq_smallest_out, q_deq_largest_out, res_valid_out,
                    res_last_out, done_out, q_enq_data_out, q_enq_tag_out, res_data_out, res_tag_out,
                    count_out, drop_count_out};
        checks++;
        if (any_out !== 1'b0) begin failures++; $display("FAIL reset_outputs: got %0b need 0", any_out); end
        rst_in = 1'b1;
        @(negedge clk);
        checks++;
        if (cand_ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b need 1", cand_ready_out); end
    endtask

    task automatic test_timing();
        int enq_at = -1;
        int rdy_at = -1;
        clear_stats();
        bp_mode = 0;
        @(negedge clk);
        cand_valid_in = 1'b1; cand_tag_in = 32'd42; cand_data_in = dfun(32'd42); cand_last_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) cand_valid_in = 1'b0;
            if (q_enq_out && enq_at < 0) enq_at = i;
            if (cand_ready_out && rdy_at < 0) rdy_at = i;
        end
        checks++;
        if (enq_at !== 2) begin failures++; $display("FAIL timing_enq: got cycle %0d need 2", enq_at); end
        checks++;
        if (rdy_at !== 4) begin failures++; $display("FAIL timing_ready: got cycle %0d need 4", rdy_at); end
        checks++;
        if (count_out !== CW'(1)) begin failures++; $display("FAIL timing_count: got %0d need 1", count_out); end
        send_cand(32'd7, 1'b1);
        for (int t = 0; t < 3000 && n_done == 0; t++) @(negedge clk);
        checks++;
        if (res_tags.size() !== 2 || res_tags[0] !== 32'd7 || res_tags[1] !== 32'd42) begin
            failures++;
            $display("FAIL timing_results: got %0d entries need 7,42", res_tags.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sorted();
        logic [TW-1:0] c[$];
        c = {32'd50, 32'd20, 32'd40, 32'd10, 32'd30};
        run_query("sorted", c, 0);
        checks++;
        if (n_enq !== 5 || n_evict !== 0) begin
            failures++; $display("FAIL sorted_enq: got enq %0d evict %0d need 5 0", n_enq, n_evict);
        end
    endtask

    task automatic test_evict();
        logic [TW-1:0] c[$];
        for (int i = 1; i <= 8; i++) c.push_back(TW'(i * 100));
        c.push_back(32'd150);
        run_query("evict", c, 0);
        checks++;
        if (n_evict !== 1 || res_tags.size() !== 8 || res_tags[1] !== 32'd150 || res_tags[7] !== 32'd700) begin
            failures++; $display("FAIL evict_specific: got evict %0d entries %0d need 1 8", n_evict, res_tags.size());
        end
    endtask

    task automatic test_drop();
        logic [TW-1:0] c[$];
        for (int i = 0; i < 8; i++) c.push_back(TW'(i * 100));
        c.push_back(32'd700);
        c.push_back(32'd900);
        run_query("drop", c, 1);
        checks++;
        if (drop_at_done !== 16'd2 || n_enq !== 8 || n_evict !== 0) begin
            failures++;
            $display("FAIL drop_specific: got drops %0d enq %0d evict %0d need 2 8 0", drop_at_done, n_enq, n_evict);
        end
    endtask

    task automatic test_backpressure();
        logic [TW-1:0] c[$];
        c = {32'd9, 32'd3, 32'd77, 32'd15};
        run_query("backpressure", c, 2);
    endtask

    task automatic test_single();
        logic [TW-1:0] c[$];
        c = {32'd33};
        run_query("single", c, 0);
        checks++;
        if (res_lasts.size() !== 1 || res_lasts[0] !== 1'b1) begin
            failures++; $display("FAIL single_last: got %0d entries need 1 with last", res_lasts.size());
        end
    endtask

    task automatic test_reset_mid_evict();
        logic [TW-1:0] c[$];
        logic any_out;
        int t = 0;
        clear_stats();
        bp_mode = 0;
        for (int i = 1; i <= 8; i++) send_cand(TW'(i * 100), 1'b0);
        send_cand(32'd150, 1'b0);
        while (!q_deq_largest_out && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (t >= 200 || count_out !== CW'(8)) begin
            failures++; $display("FAIL evict_reach: got count %0d after %0d cycles need 8", count_out, t);
        end
        rst_in = 1'b0;
        #1;
        any_out = |{cand_ready_out, q_enq_out, q_deq_smallest_out, q_deq_largest_out, res_valid_out,
                    done_out, count_out, drop_count_out};
        checks++;
        if (any_out !== 1'b0) begin failures++; $display("FAIL midreset_outputs: got %0b need 0", any_out); end
        repeat (2) @(negedge clk);
        rst_in = 1'b1;
        c = {32'd5, 32'd3, 32'd9};
        run_query("after_reset", c, 1);
    endtask

    task automatic test_random();
        for (int q = 0; q < 6; q++) begin
            logic [TW-1:0] c[$];
            int n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) c.push_back(TW'($urandom_range(0, 40)));
            run_query($sformatf("random%0d", q), c, $urandom_range(0, 1));
        end
    endtask

    initial begin
        res_ready_in = 1'b1;
        test_reset();
        test_timing();
        test_sorted();
        test_evict();
        test_drop();
        test_backpressure();
        test_single();
        test_reset_mid_evict();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
